seq_det_prog: RTL and testbench
===============================

Name: seq_det_prog

Overview:
Parametrised serial bit-sequence detector that replaces the fixed-pattern detector FSMs. The pattern, its length and the overlap mode are programmable at run time, up to PAT_W bits. Input bits are qualified by a valid strobe, and an optional saturating match counter is available. The block sits on a serial input stream and raises a one-cycle registered match pulse toward an interrupt or control block.

Parameters:
PAT_W, 8, maximum pattern length in bits (must be >= 2)
LEN_W, $clog2(PAT_W+1), width of cfg_len
CNT_W, 16, width of match_cnt (used only when SEQDET_CNT_EN is defined)

Ports:
clk  in  1  clock; all logic rises on posedge
reset  in  1  synchronous, active-high reset
en  in  1  detector enable; config is sampled on leaving IDLE
cfg_pattern  in  PAT_W  pattern; bit [cfg_len-1] is expected first, bit 0 last
cfg_len  in  LEN_W  pattern length; legal range 1..PAT_W
cfg_overlap  in  1  1 = overlapping matches allowed; 0 = restart after each match
in_valid  in  1  qualifies in_bit
in_bit  in  1  serial data bit
cnt_clr  in  1  synchronous clear of match_cnt
match  out  1  one-cycle pulse, registered
busy  out  1  1 when state != IDLE
cfg_err  out  1  1 while en=1 and cfg_len is illegal
match_cnt  out  CNT_W  saturating match count

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, shift reg=0, fill_cnt=0, match=0, cfg_err=0, match_cnt=0. busy is derived from state, so it is 0 after reset.
- Config latch: cfg_pattern, cfg_len and cfg_overlap are latched on the IDLE->FILL transition. Changes while busy are ignored.
- Shift register: shifts only on in_valid=1, sh <= {sh[PAT_W-2:0], in_bit}. in_valid=0 cycles are no-ops in every state.
- Compare: hit is a masked compare of {sh[len-2:0], in_bit} against pattern[len-1:0] on the current valid beat. When len=1, hit = (in_bit == pattern[0]).
- Latency: match=1 exactly in the cycle after the valid beat that completes the pattern; otherwise match=0.
- FSM states: IDLE, FILL, HUNT.
- IDLE:
  - en=1 and 1<=cfg_len<=PAT_W: latch config, fill_cnt=0, go to FILL.
  - en=1 and cfg_len illegal: stay in IDLE, cfg_err=1 (registered).
  - en=0: stay in IDLE, cfg_err=0.
- FILL (counting the first len bits):
  - Each valid beat increments fill_cnt.
  - On the beat where fill_cnt==len-1, compare:
    - hit and cfg_overlap=0: match next cycle, fill_cnt=0, stay in FILL.
    - otherwise: go to HUNT; match = hit.
- HUNT: every valid beat compares.
  - hit and cfg_overlap=0: match, fill_cnt=0, go to FILL.
  - hit and cfg_overlap=1: match, stay in HUNT.
- en=0 in FILL or HUNT: go to IDLE next cycle. Any partial sequence is discarded and no match is issued from that cycle on.
- Reset mid-operation: returns everything to reset values regardless of in_valid or en.

Optional Feature:
- Macro: SEQDET_CNT_EN.
- Defined:
  - match_cnt increments on every match pulse and saturates at all-ones.
  - cnt_clr=1 clears it to 0.
  - cnt_clr and a match in the same cycle gives match_cnt=1.
  - Counter is not cleared by en.
- Undefined: match_cnt is tied to 0, cnt_clr is ignored, and no counter flops are built.

Decomposition:
- Package seq_det_pkg:
  - state enum typedef {ST_IDLE, ST_FILL, ST_HUNT}, 2-bit logic.
  - localparam helper for LEN_W.
- Sub-module seq_det_sat_cnt:
  - parametrised saturating counter with inc/clr, CNT_W wide.
  - instantiated only under SEQDET_CNT_EN.
- Compare logic stays inline.

Test Plan:
1. PAT_W=8, cfg_len=4, pattern=4'b1011, overlap=1, stream 1,0,1,1,0,1,1 one per cycle -> match pulses after beat 4 and after beat 7; match_cnt=2.
2. Same stream with overlap=0 -> single match after beat 4, none after beat 7; busy stays 1.
3. Pattern 1011 sent with in_valid=0 gaps of 1-3 cycles between bits -> exactly one match, one cycle after the 4th valid beat; no match on idle cycles.
4. Send 1,0,1, then drop en for 2 cycles, re-enable, send 1 -> no match; then send 1,0,1,1 -> match after the 4th bit.
5. cfg_len=0, then cfg_len=9 with en=1 -> cfg_err=1 the next cycle, busy=0, no match; cfg_len=4 -> cfg_err=0 and busy=1.
6. SEQDET_CNT_EN defined, CNT_W=2, 5 matches -> match_cnt saturates at 3; cnt_clr coincident with a match -> 1. Macro undefined -> match_cnt=0 throughout.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seq_det_pkg;

  // Detector controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HUNT = 2'd2
  } state_t;

  // Width needed to hold a pattern length in the range 0..pat_w.
  function automatic int len_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  localparam int PAT_W_DEF = 8;
  localparam int LEN_W_DEF = len_width(PAT_W_DEF);

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear. A clear coinciding with an
// increment leaves the count at 1 so that the coincident event is not lost.
module seq_det_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  // Clear wins over hold; increment stops at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial bit-sequence detector.
// Pattern (MSB of the active length first), length and overlap mode are
// captured when the detector leaves IDLE. A registered one-cycle match pulse
// follows the valid beat that completes the pattern.
// Optional feature macro: SEQDET_CNT_EN builds a saturating match counter;
// without it match_cnt is constant zero and cnt_clr is ignored.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = len_width(PAT_W),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cnt_clr,
  output logic             match,
  output logic             busy,
  output logic             cfg_err,
  output logic [CNT_W-1:0] match_cnt
);

  state_t           state_reg, state_next;
  logic [PAT_W-1:0] sh_reg, sh_next;
  logic [LEN_W-1:0] fill_cnt_reg, fill_cnt_next;
  logic [PAT_W-1:0] pat_reg, pat_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic             ovl_reg, ovl_next;
  logic             match_reg, match_next;
  logic             cfg_err_reg, cfg_err_next;

  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] len_mask;
  logic             hit;
  logic             len_legal;

  // Only the low PAT_W-1 history bits feed the compare; the oldest bit is
  // kept so the register matches the full pattern width.
  logic unused_sh_msb;
  assign unused_sh_msb = sh_reg[PAT_W-1];

  assign len_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));

  // Candidate word: stored history plus the bit arriving this cycle.
  assign cand = {sh_reg[PAT_W-2:0], in_bit};

  // Bits below the latched length take part in the compare.
  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign len_mask[gi] = (LEN_W'(gi) < len_reg);
    end
  endgenerate

  assign hit = (((cand ^ pat_reg) & len_mask) == '0);

  // Shift history on every qualified beat.
  always_comb begin
    sh_next = sh_reg;
    if (in_valid) begin
      sh_next = cand;
    end
  end

  // Controller: config capture, fill counting and match decision.
  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    pat_next      = pat_reg;
    len_next      = len_reg;
    ovl_next      = ovl_reg;
    match_next    = 1'b0;
    cfg_err_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (en) begin
          if (len_legal) begin
            pat_next      = cfg_pattern;
            len_next      = cfg_len;
            ovl_next      = cfg_overlap;
            fill_cnt_next = '0;
            state_next    = ST_FILL;
          end else begin
            cfg_err_next = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (!en) begin
          state_next = ST_IDLE;
        end else if (in_valid) begin
          if (fill_cnt_reg == (len_reg - LEN_W'(1))) begin
            match_next = hit;
            if (hit && !ovl_reg) begin
              fill_cnt_next = '0;
            end else begin
              state_next = ST_HUNT;
            end
          end else begin
            fill_cnt_next = fill_cnt_reg + LEN_W'(1);
          end
        end
      end
      ST_HUNT: begin
        if (!en) begin
          state_next = ST_IDLE;
        end else if (in_valid && hit) begin
          match_next = 1'b1;
          if (!ovl_reg) begin
            fill_cnt_next = '0;
            state_next    = ST_FILL;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, history, latched config and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      sh_reg       <= '0;
      fill_cnt_reg <= '0;
      pat_reg      <= '0;
      len_reg      <= '0;
      ovl_reg      <= 1'b0;
      match_reg    <= 1'b0;
      cfg_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sh_reg       <= sh_next;
      fill_cnt_reg <= fill_cnt_next;
      pat_reg      <= pat_next;
      len_reg      <= len_next;
      ovl_reg      <= ovl_next;
      match_reg    <= match_next;
      cfg_err_reg  <= cfg_err_next;
    end
  end

  assign match   = match_reg;
  assign busy    = (state_reg != ST_IDLE);
  assign cfg_err = cfg_err_reg;

`ifdef SEQDET_CNT_EN
  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_sat_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match_reg),
    .clr   (cnt_clr),
    .cnt   (match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Vector-table bench for seq_det_prog with an expected-output queue.
module tb_seq_det_prog;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 2;

`ifdef SEQDET_CNT_EN
  localparam int EXP_SAT = 3;
  localparam int EXP_CLR = 1;
`else
  localparam int EXP_SAT = 0;
  localparam int EXP_CLR = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             in_valid;
  logic             in_bit;
  logic             cnt_clr;
  logic             match;
  logic             busy;
  logic             cfg_err;
  logic [CNT_W-1:0] match_cnt;

  seq_det_prog #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cnt_clr     (cnt_clr),
    .match       (match),
    .busy        (busy),
    .cfg_err     (cfg_err),
    .match_cnt   (match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             en;
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pat;
    logic             ovl;
    logic             vld;
    logic             b;
    logic             clr;
    logic             m;
    logic             busy;
    logic             err;
  } vec_t;

  typedef struct {
    logic m;
    logic busy;
    logic err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  vec_t cur;
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic void set_cfg(input logic [LEN_W-1:0] l, input logic [PAT_W-1:0] p,
                                  input logic o);
    cur.len = l;
    cur.pat = p;
    cur.ovl = o;
  endfunction

  function automatic void add_row(input logic r, input logic e, input logic v, input logic b,
                                  input logic c, input logic m, input logic bz, input logic er);
    vec_t x;
    x      = cur;
    x.rst  = r;
    x.en   = e;
    x.vld  = v;
    x.b    = b;
    x.clr  = c;
    x.m    = m;
    x.busy = bz;
    x.err  = er;
    tbl.push_back(x);
  endfunction

  // s: '1'/'0' valid beats, '-' idle cycle with bit=1, '_' idle with bit=0.
  // me: expected match after each cycle. Detector stays enabled and busy.
  function automatic void add_stream(input string s, input string me);
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      byte mc;
      c  = s[i];
      mc = me[i];
      add_row(1'b0, 1'b1, (c == "1") || (c == "0"), (c == "1") || (c == "-"), 1'b0,
              mc == "1", 1'b1, 1'b0);
    end
  endfunction

  // Drive one cycle, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    reset       = v.rst;
    en          = v.en;
    cfg_len     = v.len;
    cfg_pattern = v.pat;
    cfg_overlap = v.ovl;
    in_valid    = v.vld;
    in_bit      = v.b;
    cnt_clr     = v.clr;
    sb_q.push_back('{m: v.m, busy: v.busy, err: v.err});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    txn++;
    $display("txn %0d %s: rst=%b en=%b len=%0d vld=%b bit=%b -> match=%b busy=%b err=%b cnt=%0d",
             txn, tag, v.rst, v.en, v.len, v.vld, v.b, match, busy, cfg_err, match_cnt);
    check1({tag, " match"}, 32'(match), 32'(e.m));
    check1({tag, " busy"}, 32'(busy), 32'(e.busy));
    check1({tag, " cfg_err"}, 32'(cfg_err), 32'(e.err));
`ifndef SEQDET_CNT_EN
    check1({tag, " match_cnt"}, 32'(match_cnt), 32'd0);
`endif
  endtask

  initial begin
    cur = '{rst: 1'b0, en: 1'b0, len: '0, pat: '0, ovl: 1'b0, vld: 1'b0, b: 1'b0,
            clr: 1'b0, m: 1'b0, busy: 1'b0, err: 1'b0};

    // Overlapping 1011 on 1011011: two matches.
    set_cfg(4'd4, 8'h0B, 1'b1);
    add_row(0, 1, 0, 0, 0, 0, 1, 0);
    add_stream("1011011", "0001001");
    add_row(0, 0, 0, 0, 0, 0, 0, 0);
    // Non-overlapping: restart after first match, none at beat 7.
    set_cfg(4'd4, 8'h0B, 1'b0);
    add_row(0, 1, 0, 0, 0, 0, 1, 0);
    add_stream("1011011", "0001000");
    add_row(0, 0, 0, 0, 0, 0, 0, 0);
    // Invalid gaps of 1..3 cycles between pattern bits.
    set_cfg(4'd4, 8'h0B, 1'b1);
    add_row(0, 1, 0, 0, 0, 0, 1, 0);
    add_stream("1-0-_1_-_1-", "00000000010");
    add_row(0, 0, 0, 0, 0, 0, 0, 0);
    // Enable drop discards the partial 101.
    add_row(0, 1, 0, 0, 0, 0, 1, 0);
    add_stream("101", "000");
    add_row(0, 0, 0, 0, 0, 0, 0, 0);
    add_row(0, 0, 0, 0, 0, 0, 0, 0);
    add_row(0, 1, 0, 0, 0, 0, 1, 0);
    add_stream("11011", "00001");
    add_stream("01", "00");
    // Completing beat coincides with en=0: no match.
    add_row(0, 0, 1, 1, 0, 0, 0, 0);
    // Illegal lengths.
    set_cfg(4'd0, 8'h0B, 1'b1);
    add_row(0, 1, 0, 0, 0, 0, 0, 1);
    add_row(0, 0, 0, 0, 0, 0, 0, 0);
    set_cfg(4'd9, 8'h0B, 1'b1);
    add_row(0, 1, 1, 1, 0, 0, 0, 1);
    set_cfg(4'd4, 8'h0B, 1'b1);
    add_row(0, 1, 0, 0, 0, 0, 1, 0);
    add_row(0, 0, 0, 0, 0, 0, 0, 0);
    // Length 1, overlap and non-overlap.
    set_cfg(4'd1, 8'h01, 1'b1);
    add_row(0, 1, 0, 0, 0, 0, 1, 0);
    add_stream("101", "101");
    add_row(0, 0, 0, 0, 0, 0, 0, 0);
    set_cfg(4'd1, 8'h01, 1'b0);
    add_row(0, 1, 0, 0, 0, 0, 1, 0);
    add_stream("110", "110");
    add_row(0, 0, 0, 0, 0, 0, 0, 0);
    // Full-width pattern.
    set_cfg(4'd8, 8'hB3, 1'b0);
    add_row(0, 1, 0, 0, 0, 0, 1, 0);
    add_stream("10110011", "00000001");
    add_row(0, 0, 0, 0, 0, 0, 0, 0);
    // Reset mid-sequence, then a fresh full match.
    set_cfg(4'd4, 8'h0B, 1'b1);
    add_row(0, 1, 0, 0, 0, 0, 1, 0);
    add_stream("101", "000");
    add_row(1, 1, 1, 1, 0, 0, 0, 0);
    add_row(0, 1, 0, 0, 0, 0, 1, 0);
    add_stream("1011", "0001");
    add_row(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with busy-looking inputs held.
    reset       = 1'b1;
    en          = 1'b1;
    cfg_len     = 4'd4;
    cfg_pattern = 8'h0B;
    cfg_overlap = 1'b1;
    in_valid    = 1'b1;
    in_bit      = 1'b1;
    cnt_clr     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check1("reset match", 32'(match), 32'd0);
    check1("reset busy", 32'(busy), 32'd0);
    check1("reset cfg_err", 32'(cfg_err), 32'd0);
    check1("reset match_cnt", 32'(match_cnt), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("v%0d", i));
    end

    // Counter: clear, five matches saturate, clear coincident with a match.
    tbl.delete();
    add_row(0, 0, 0, 0, 1, 0, 0, 0);
    set_cfg(4'd1, 8'h01, 1'b1);
    add_row(0, 1, 0, 0, 0, 0, 1, 0);
    add_stream("11111", "11111");
    add_row(0, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("c%0d", i));
      if (i == 0) check1("cnt after clr", 32'(match_cnt), 32'd0);
    end
    check1("cnt saturated", 32'(match_cnt), 32'(EXP_SAT));
    tbl.delete();
    add_stream("1", "1");
    add_row(0, 1, 0, 0, 1, 0, 1, 0);
    add_row(0, 1, 0, 0, 0, 0, 1, 0);
    apply(tbl[0], "k0");
    apply(tbl[1], "k1");
    check1("cnt clr with match", 32'(match_cnt), 32'(EXP_CLR));
    apply(tbl[2], "k2");
    check1("cnt hold", 32'(match_cnt), 32'(EXP_CLR));

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left expected 0", sb_q.size());
    end
    checks++;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
